// File: rtl/axi_stream_fifo.sv
// rtl/axi_stream_fifo.sv - First-word-fall-through AXI-stream FIFO with occupancy and almost_full.
// Optional AXIS_FIFO_TLAST_EN adds s_tlast/m_tlast carried alongside each beat.
module axi_stream_fifo #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N*DATA_WIDTH-1:0]       s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [N*DATA_WIDTH-1:0]       m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
`ifdef AXIS_FIFO_TLAST_EN
    input  logic                          s_tlast,
    output logic                          m_tlast,
`endif
    output logic [$clog2(DEPTH):0]        count,
    output logic                          almost_full
);

    localparam int W  = N * DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_ready;
    logic            w_valid;

    // Both handshakes depend only on registered occupancy, so there is no
    // combinational path from m_tready to s_tready.
    assign w_ready = (r_count != C_DEPTH);
    assign w_valid = (r_count != '0);
    assign w_push  = s_tvalid & w_ready;
    assign w_pop   = w_valid & m_tready;

    assign s_tready    = w_ready;
    assign m_tvalid    = w_valid;
    assign m_tdata     = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign almost_full = (r_count >= C_AF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not cleared on reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_tdata;
        end
    end

`ifdef AXIS_FIFO_TLAST_EN
    logic r_last [DEPTH];

    assign m_tlast = r_last[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_last[r_wr_ptr] <= s_tlast;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_fifo.sv
// tb/tb_axi_stream_fifo.sv - Directed plus randomized bench against a queue reference model.
module tb_axi_stream_fifo;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tlast;
    logic [2:0]  count;
    logic        almost_full;

    int n_total = 0;
    int n_bad   = 0;

    // Each model entry holds {tlast, data}.
    logic [32:0] q[$];

    always #5 clk = ~clk;

    axi_stream_fifo #(
        .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
`ifdef AXIS_FIFO_TLAST_EN
        .s_tlast(s_tlast),
        .m_tlast(m_tlast),
`endif
        .count(count),
        .almost_full(almost_full)
    );

`ifndef AXIS_FIFO_TLAST_EN
    assign m_tlast = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all visible outputs against the model state.
    task automatic check_outputs();
        check("count", 64'(count), 64'(q.size()));
        check("s_tready", 64'(s_tready), 64'(q.size() < DEPTH));
        check("m_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
        check("almost_full", 64'(almost_full), 64'(q.size() >= AF));
        if (q.size() > 0) begin
            check("m_tdata", 64'(m_tdata), 64'(q[0][31:0]));
`ifdef AXIS_FIFO_TLAST_EN
            check("m_tlast", 64'(m_tlast), 64'(q[0][32]));
`endif
        end
    endtask

    // Called just after a negedge: check, drive, clock, update model.
    task automatic cyc(input logic rst, input logic sv, input logic [31:0] sd,
                       input logic sl, input logic mr);
        logic do_push;
        logic do_pop;
        check_outputs();
        reset    = rst;
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        do_push  = sv && (q.size() < DEPTH);
        do_pop   = mr && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({sl, sd});
        end
        @(negedge clk);
    endtask

    logic [31:0] held;

    initial begin
        @(negedge clk);
        // Reset/idle: two reset cycles then idle check.
        q.delete();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fill to full, then hold a 5th beat that must not be accepted.
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 32'h11111111 * i, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_head", 64'(m_tdata), 64'h11111111);

        // Drain in order.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("drained_valid", 64'(m_tvalid), 64'd0);

        // Streaming with wrap: 10 beats, count stays at 1.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'(i), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Back-pressure hold with 3 queued beats.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        held = m_tdata;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("hold_stable1", 64'(m_tdata), 64'(held));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("hold_stable2", 64'(m_tdata), 64'(held));
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Reset mid-stream at count=3, then a tagged beat is the next one out.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        check("pre_reset_count", 64'(count), 64'd3);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("post_reset_count", 64'(count), 64'd0);
        check("post_reset_valid", 64'(m_tvalid), 64'd0);
        cyc(1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        check("a5_head", 64'(m_tdata), 64'hA5A5A5A5);
        cyc(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                ($urandom_range(0, 99) < 60),
                $urandom,
                1'($urandom),
                ($urandom_range(0, 99) < 50));
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
